// File: rtl/memory_access.sv
// memory_access: M stage of the five-stage MIPS pipeline.
// Latches E-stage results, runs loads/stores over a req/ack data bus with
// wait states, builds byte enables, replicates store data, extends loads.
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned accesses are flagged on
// M_addr_err and never issued; without it the low address bits are ignored.
module memory_access (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] E_instr,
   input  logic [31:0] E_WD_M,
   input  logic [31:0] E_ALUResult,
   input  logic [4:0]  E_A3_M,
   input  logic [31:0] M_Forward2,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [3:0]  dm_byteen,
   output logic [31:0] dm_wdata,
   output logic        M_busy,
   output logic [31:0] M_WD_W,
   output logic [4:0]  M_A3_W,
   output logic [31:0] M_instr_W,
   output logic        M_addr_err
);
   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SW  = 6'b101011;

   typedef enum logic [1:0] {IDLE, ACC1, WAIT} state_t;

   function automatic logic is_load(input logic [5:0] op);
      return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
             (op == OP_LHU) || (op == OP_LW);
   endfunction

   function automatic logic is_store(input logic [5:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

`ifdef MEM_ALIGN_CHECK_EN
   function automatic logic misaligned(input logic [5:0] op, input logic [1:0] a);
      logic m;
      m = 1'b0;
      case (op)
         OP_LW, OP_SW:          m = (a != 2'b00);
         OP_LH, OP_LHU, OP_SH:  m = a[0];
         default:               m = 1'b0;
      endcase
      return m;
   endfunction
`endif

   state_t      state_q, state_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] wd_q, wd_d;
   logic [31:0] addr_q, addr_d;
   logic [4:0]  a3_q, a3_d;
   logic [31:0] wbuf_q, wbuf_d;

   logic [5:0]  m_op, e_op;
   logic        m_ld, m_st, e_start, m_err;
   logic [3:0]  be;
   logic [31:0] st_fwd;
   logic [7:0]  ld_b;
   logic [15:0] ld_h;
   logic [31:0] ld_data;

   assign m_op = instr_q[31:26];
   assign e_op = E_instr[31:26];
   assign m_ld = is_load(m_op);
   assign m_st = is_store(m_op);

`ifdef MEM_ALIGN_CHECK_EN
   // A misaligned op is captured but never starts a bus access.
   assign e_start = (is_load(e_op) | is_store(e_op)) & ~misaligned(e_op, E_ALUResult[1:0]);
   assign m_err   = (m_ld | m_st) & misaligned(m_op, addr_q[1:0]);
`else
   assign e_start = is_load(e_op) | is_store(e_op);
   assign m_err   = 1'b0;
`endif

   // Next state: whenever M accepts a new op (not busy) the access for that op
   // starts, so an ack cycle can chain straight into the next memory op.
   always_comb begin
      state_d = state_q;
      if (!M_busy)
         state_d = e_start ? ACC1 : IDLE;
      else if (state_q == ACC1)
         state_d = WAIT;
   end

   // M pipeline register loads when not stalled; store buffer captures in ACC1.
   always_comb begin
      instr_d = instr_q;
      wd_d    = wd_q;
      addr_d  = addr_q;
      a3_d    = a3_q;
      wbuf_d  = wbuf_q;
      if (!M_busy) begin
         instr_d = E_instr;
         wd_d    = E_WD_M;
         addr_d  = E_ALUResult;
         a3_d    = E_A3_M;
      end
      if (state_q == ACC1)
         wbuf_d = st_fwd;
   end

   // State and pipeline registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         instr_q <= '0;
         wd_q    <= '0;
         addr_q  <= '0;
         a3_q    <= '0;
         wbuf_q  <= '0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         wd_q    <= wd_d;
         addr_q  <= addr_d;
         a3_q    <= a3_d;
         wbuf_q  <= wbuf_d;
      end
   end

   // Byte enables and replicated store data from the live forwarded rt value.
   always_comb begin
      be     = 4'b0000;
      st_fwd = M_Forward2;
      case (m_op)
         OP_SW: be = 4'b1111;
         OP_SH: begin
            be     = addr_q[1] ? 4'b1100 : 4'b0011;
            st_fwd = {2{M_Forward2[15:0]}};
         end
         OP_SB: begin
            be     = 4'b0001 << addr_q[1:0];
            st_fwd = {4{M_Forward2[7:0]}};
         end
         default: ;
      endcase
   end

   // Load lane select and sign/zero extension.
   always_comb begin
      case (addr_q[1:0])
         2'd0:    ld_b = dm_rdata[7:0];
         2'd1:    ld_b = dm_rdata[15:8];
         2'd2:    ld_b = dm_rdata[23:16];
         default: ld_b = dm_rdata[31:24];
      endcase
      ld_h = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
      case (m_op)
         OP_LB:   ld_data = {{24{ld_b[7]}}, ld_b};
         OP_LBU:  ld_data = {24'h0, ld_b};
         OP_LH:   ld_data = {{16{ld_h[15]}}, ld_h};
         OP_LHU:  ld_data = {16'h0, ld_h};
         default: ld_data = dm_rdata;
      endcase
   end

   assign dm_req     = (state_q == ACC1) || (state_q == WAIT);
   assign M_busy     = dm_req & ~dm_ack;
   assign dm_we      = dm_req & m_st;
   assign dm_addr    = dm_req ? {addr_q[31:2], 2'b00} : 32'h0;
   assign dm_byteen  = dm_req ? be : 4'h0;
   // In WAIT the buffered copy is used so forwarding changes cannot leak in.
   assign dm_wdata   = !dm_we ? 32'h0 : (state_q == ACC1) ? st_fwd : wbuf_q;
   assign M_WD_W     = m_ld ? ld_data : wd_q;
   assign M_A3_W     = (M_busy | m_err) ? 5'd0 : a3_q;
   assign M_instr_W  = instr_q;
   assign M_addr_err = m_err;

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed scenarios plus randomized
// accesses checked against a byte-lane reference model.
module tb_memory_access;
   localparam logic [5:0] LB  = 6'b100000;
   localparam logic [5:0] LBU = 6'b100100;
   localparam logic [5:0] LH  = 6'b100001;
   localparam logic [5:0] LHU = 6'b100101;
   localparam logic [5:0] LW  = 6'b100011;
   localparam logic [5:0] SB  = 6'b101000;
   localparam logic [5:0] SH  = 6'b101001;
   localparam logic [5:0] SW  = 6'b101011;
   localparam logic [5:0] ALU = 6'b000000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] E_instr = '0, E_WD_M = '0, E_ALUResult = '0, M_Forward2 = '0, dm_rdata = '0;
   logic [4:0]  E_A3_M = '0;
   logic        dm_ack = 1'b0;
   logic        dm_req, dm_we, M_busy, M_addr_err;
   logic [31:0] dm_addr, dm_wdata, M_WD_W, M_instr_W;
   logic [3:0]  dm_byteen;
   logic [4:0]  M_A3_W;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   memory_access dut (
      .clk(clk), .reset(reset), .E_instr(E_instr), .E_WD_M(E_WD_M),
      .E_ALUResult(E_ALUResult), .E_A3_M(E_A3_M), .M_Forward2(M_Forward2),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_req(dm_req), .dm_we(dm_we),
      .dm_addr(dm_addr), .dm_byteen(dm_byteen), .dm_wdata(dm_wdata),
      .M_busy(M_busy), .M_WD_W(M_WD_W), .M_A3_W(M_A3_W),
      .M_instr_W(M_instr_W), .M_addr_err(M_addr_err)
   );

   // Reference: an access covers `size` bytes starting at the address rounded
   // down to size within the word; store data repeats the low `size` bytes.
   function automatic void model(input logic [5:0] op, input logic [31:0] addr,
                                 input logic [31:0] fwd, input logic [31:0] rdata,
                                 output logic [3:0] be, output logic [31:0] wd,
                                 output logic [31:0] ld);
      int size, start;
      bit sgn, st;
      logic [63:0] v;
      size = 4; sgn = 0; st = 0;
      case (op)
         LB:  begin size = 1; sgn = 1; end
         LBU: size = 1;
         LH:  begin size = 2; sgn = 1; end
         LHU: size = 2;
         SB:  begin size = 1; st = 1; end
         SH:  begin size = 2; st = 1; end
         SW:  begin size = 4; st = 1; end
         default: size = 4;
      endcase
      start = ((addr % 4) / size) * size;
      be = '0; wd = '0; ld = '0; v = '0;
      for (int i = 0; i < 4; i++) begin
         if (st && i >= start && i < start + size) be[i] = 1'b1;
         if (st) wd[8*i +: 8] = fwd[8*(i % size) +: 8];
      end
      if (!st) begin
         for (int i = 0; i < size; i++) v = v | (64'(rdata[8*(start+i) +: 8]) << (8*i));
         if (sgn && v[8*size-1]) v = v - (64'd1 << (8*size));
         ld = v[31:0];
      end
   endfunction

   function automatic logic [5:0] pick_op(input int k);
      case (k)
         0: return LB;  1: return LBU; 2: return LH;  3: return LHU;
         4: return LW;  5: return SB;  6: return SH;  7: return SW;
         default: return ALU;
      endcase
   endfunction

   task automatic drive_e(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] a3,
                          input logic [31:0] addr, input logic [31:0] wd);
      E_instr = {op, 5'd1, rt, addr[15:0]};
      E_ALUResult = addr;
      E_WD_M = wd;
      E_A3_M = a3;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      dm_ack = 1'b1;
      @(negedge clk); #1;
      checks++; if (dm_req !== 1'b0) $display("FAIL reset_dm_req got %h exp 0", dm_req); else passes++;
      checks++; if (dm_we !== 1'b0) $display("FAIL reset_dm_we got %h exp 0", dm_we); else passes++;
      checks++; if (dm_addr !== 32'h0) $display("FAIL reset_dm_addr got %h exp 0", dm_addr); else passes++;
      checks++; if (dm_byteen !== 4'h0) $display("FAIL reset_dm_byteen got %h exp 0", dm_byteen); else passes++;
      checks++; if (dm_wdata !== 32'h0) $display("FAIL reset_dm_wdata got %h exp 0", dm_wdata); else passes++;
      checks++; if (M_busy !== 1'b0) $display("FAIL reset_M_busy got %h exp 0", M_busy); else passes++;
      checks++; if (M_WD_W !== 32'h0) $display("FAIL reset_M_WD_W got %h exp 0", M_WD_W); else passes++;
      checks++; if (M_A3_W !== 5'h0) $display("FAIL reset_M_A3_W got %h exp 0", M_A3_W); else passes++;
      checks++; if (M_instr_W !== 32'h0) $display("FAIL reset_M_instr_W got %h exp 0", M_instr_W); else passes++;
      checks++; if (M_addr_err !== 1'b0) $display("FAIL reset_M_addr_err got %h exp 0", M_addr_err); else passes++;
      dm_ack = 1'b0;
      reset = 1'b0;
   endtask

   task automatic test_sw_no_wait();
      @(negedge clk); drive_e(SW, 5'd5, 5'd0, 32'h10, 32'h0);
      @(negedge clk); drive_e(ALU, 5'd0, 5'd0, 32'h0, 32'h0);
      M_Forward2 = 32'h12345678; dm_ack = 1'b1; #1;
      checks++; if (dm_req !== 1'b1) $display("FAIL sw_req got %h exp 1", dm_req); else passes++;
      checks++; if (dm_we !== 1'b1) $display("FAIL sw_we got %h exp 1", dm_we); else passes++;
      checks++; if (dm_addr !== 32'h10) $display("FAIL sw_addr got %h exp 10", dm_addr); else passes++;
      checks++; if (dm_byteen !== 4'b1111) $display("FAIL sw_byteen got %b exp 1111", dm_byteen); else passes++;
      checks++; if (dm_wdata !== 32'h12345678) $display("FAIL sw_wdata got %h exp 12345678", dm_wdata); else passes++;
      checks++; if (M_busy !== 1'b0) $display("FAIL sw_busy got %h exp 0", M_busy); else passes++;
      checks++; if (M_A3_W !== 5'd0) $display("FAIL sw_a3 got %h exp 0", M_A3_W); else passes++;
      @(negedge clk); dm_ack = 1'b0; #1;
      checks++; if (dm_req !== 1'b0) $display("FAIL sw_req_after got %h exp 0", dm_req); else passes++;
   endtask

   task automatic test_lb_wait();
      int nbusy;
      nbusy = 0;
      @(negedge clk); drive_e(LB, 5'd7, 5'd7, 32'h13, 32'hDEAD);
      @(negedge clk); drive_e(ALU, 5'd0, 5'd0, 32'h0, 32'h0);
      dm_rdata = 32'h80FFFFFF;
      for (int w = 0; w <= 2; w++) begin
         dm_ack = (w == 2); #1;
         if (M_busy === 1'b1) nbusy++;
         checks++; if (dm_addr !== 32'h10) $display("FAIL lb_addr got %h exp 10", dm_addr); else passes++;
         if (w < 2) begin
            checks++; if (M_A3_W !== 5'd0) $display("FAIL lb_bubble_a3 got %h exp 0", M_A3_W); else passes++;
         end else begin
            checks++; if (M_WD_W !== 32'hFFFFFF80) $display("FAIL lb_data got %h exp ffffff80", M_WD_W); else passes++;
            checks++; if (M_A3_W !== 5'd7) $display("FAIL lb_a3 got %h exp 7", M_A3_W); else passes++;
         end
         @(negedge clk);
      end
      dm_ack = 1'b0;
      checks++; if (nbusy != 2) $display("FAIL lb_busy_cycles got %0d exp 2", nbusy); else passes++;
   endtask

   task automatic test_sh_forward_hold();
      @(negedge clk); drive_e(SH, 5'd3, 5'd0, 32'h22, 32'h0);
      @(negedge clk); drive_e(ALU, 5'd0, 5'd0, 32'h0, 32'h0);
      M_Forward2 = 32'hAAAABEEF;
      for (int w = 0; w <= 3; w++) begin
         dm_ack = (w == 3);
         if (w > 0) M_Forward2 = 32'h0;
         #1;
         checks++; if (dm_byteen !== 4'b1100) $display("FAIL sh_byteen_c%0d got %b exp 1100", w, dm_byteen); else passes++;
         checks++; if (dm_wdata !== 32'hBEEFBEEF) $display("FAIL sh_wdata_c%0d got %h exp beefbeef", w, dm_wdata); else passes++;
         checks++; if (dm_addr !== 32'h20) $display("FAIL sh_addr_c%0d got %h exp 20", w, dm_addr); else passes++;
         @(negedge clk);
      end
      dm_ack = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] addu_instr;
      @(negedge clk); drive_e(LHU, 5'd9, 5'd9, 32'h6, 32'h0);
      @(negedge clk);
      drive_e(ALU, 5'd0, 5'd3, 32'h0, 32'h55);
      addu_instr = E_instr;
      dm_rdata = 32'h80010000; dm_ack = 1'b1; #1;
      checks++; if (M_WD_W !== 32'h00008001) $display("FAIL b2b_lhu_data got %h exp 00008001", M_WD_W); else passes++;
      checks++; if (M_A3_W !== 5'd9) $display("FAIL b2b_lhu_a3 got %h exp 9", M_A3_W); else passes++;
      checks++; if (M_busy !== 1'b0) $display("FAIL b2b_busy got %h exp 0", M_busy); else passes++;
      @(negedge clk); dm_ack = 1'b0;
      drive_e(ALU, 5'd0, 5'd0, 32'h0, 32'h0); #1;
      checks++; if (M_instr_W !== addu_instr) $display("FAIL b2b_addu_instr got %h exp %h", M_instr_W, addu_instr); else passes++;
      checks++; if (M_WD_W !== 32'h55) $display("FAIL b2b_addu_data got %h exp 55", M_WD_W); else passes++;
      checks++; if (M_A3_W !== 5'd3) $display("FAIL b2b_addu_a3 got %h exp 3", M_A3_W); else passes++;
      checks++; if (dm_req !== 1'b0) $display("FAIL b2b_addu_req got %h exp 0", dm_req); else passes++;
   endtask

   task automatic test_reset_mid_access();
      @(negedge clk); drive_e(LW, 5'd4, 5'd4, 32'h40, 32'h0);
      @(negedge clk); drive_e(ALU, 5'd0, 5'd0, 32'h0, 32'h0);
      dm_ack = 1'b0;
      @(negedge clk); #1;
      checks++; if (dm_req !== 1'b1) $display("FAIL rst_mid_wait_req got %h exp 1", dm_req); else passes++;
      #1 reset = 1'b1; #1;
      checks++; if (dm_req !== 1'b0) $display("FAIL rst_mid_req got %h exp 0", dm_req); else passes++;
      checks++; if (M_busy !== 1'b0) $display("FAIL rst_mid_busy got %h exp 0", M_busy); else passes++;
      @(negedge clk); reset = 1'b0; dm_ack = 1'b1; #1;
      checks++; if (M_A3_W !== 5'd0) $display("FAIL rst_stray_ack_a3 got %h exp 0", M_A3_W); else passes++;
      @(negedge clk); #1;
      checks++; if (dm_req !== 1'b0) $display("FAIL rst_stray_ack_req got %h exp 0", dm_req); else passes++;
      checks++; if (M_A3_W !== 5'd0) $display("FAIL rst_stray_ack_a3b got %h exp 0", M_A3_W); else passes++;
      dm_ack = 1'b0;
   endtask

   task automatic test_misaligned();
      @(negedge clk); drive_e(LW, 5'd2, 5'd2, 32'h6, 32'h0);
      @(negedge clk); drive_e(ALU, 5'd0, 5'd0, 32'h0, 32'h0);
      dm_rdata = 32'hCAFEF00D;
`ifdef MEM_ALIGN_CHECK_EN
      dm_ack = 1'b0; #1;
      checks++; if (M_addr_err !== 1'b1) $display("FAIL mis_err got %h exp 1", M_addr_err); else passes++;
      checks++; if (dm_req !== 1'b0) $display("FAIL mis_req got %h exp 0", dm_req); else passes++;
      checks++; if (M_A3_W !== 5'd0) $display("FAIL mis_a3 got %h exp 0", M_A3_W); else passes++;
      @(negedge clk); #1;
      checks++; if (M_addr_err !== 1'b0) $display("FAIL mis_err_after got %h exp 0", M_addr_err); else passes++;
      checks++; if (dm_req !== 1'b0) $display("FAIL mis_req_after got %h exp 0", dm_req); else passes++;
`else
      dm_ack = 1'b1; #1;
      checks++; if (dm_req !== 1'b1) $display("FAIL mis_req got %h exp 1", dm_req); else passes++;
      checks++; if (dm_addr !== 32'h4) $display("FAIL mis_addr got %h exp 4", dm_addr); else passes++;
      checks++; if (M_WD_W !== 32'hCAFEF00D) $display("FAIL mis_data got %h exp cafef00d", M_WD_W); else passes++;
      checks++; if (M_A3_W !== 5'd2) $display("FAIL mis_a3 got %h exp 2", M_A3_W); else passes++;
      checks++; if (M_addr_err !== 1'b0) $display("FAIL mis_err got %h exp 0", M_addr_err); else passes++;
      @(negedge clk); dm_ack = 1'b0;
`endif
   endtask

   task automatic test_random();
      logic [5:0]  op;
      logic [31:0] addr, wd, fwd0, rd, instr, exp_wd, exp_ld, exp_addr;
      logic [4:0]  rt, a3;
      logic [3:0]  exp_be;
      int nw;
      bit st;
      for (int n = 0; n < 40; n++) begin
         op   = pick_op($urandom_range(0, 8));
         addr = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
         if (op == LW || op == SW) addr[1:0] = 2'b00;
         else if (op == LH || op == LHU || op == SH) addr[0] = 1'b0;
`endif
         rt   = 5'($urandom_range(1, 31));
         st   = (op[5:3] == 3'b101);
         a3   = st ? 5'd0 : rt;
         wd   = $urandom;
         fwd0 = $urandom;
         rd   = $urandom;
         nw   = $urandom_range(0, 3);
         @(negedge clk); drive_e(op, rt, a3, addr, wd);
         instr = E_instr;
         @(negedge clk); drive_e(ALU, 5'd0, 5'd0, 32'h0, 32'h0);
         if (op == ALU) begin
            #1;
            checks++; if (dm_req !== 1'b0) $display("FAIL rnd%0d_alu_req got %h exp 0", n, dm_req); else passes++;
            checks++; if (M_WD_W !== wd) $display("FAIL rnd%0d_alu_wd got %h exp %h", n, M_WD_W, wd); else passes++;
            checks++; if (M_A3_W !== a3) $display("FAIL rnd%0d_alu_a3 got %h exp %h", n, M_A3_W, a3); else passes++;
            checks++; if (M_instr_W !== instr) $display("FAIL rnd%0d_alu_instr got %h exp %h", n, M_instr_W, instr); else passes++;
         end else begin
            model(op, addr, fwd0, rd, exp_be, exp_wd, exp_ld);
            exp_addr = addr - (addr % 4);
            M_Forward2 = fwd0;
            for (int w = 0; w <= nw; w++) begin
               dm_ack = (w == nw);
               dm_rdata = (w == nw) ? rd : $urandom;
               if (w > 0) M_Forward2 = $urandom;
               #1;
               checks++; if (dm_req !== 1'b1) $display("FAIL rnd%0d_req got %h exp 1", n, dm_req); else passes++;
               checks++; if (dm_we !== st) $display("FAIL rnd%0d_we got %h exp %h", n, dm_we, st); else passes++;
               checks++; if (dm_addr !== exp_addr) $display("FAIL rnd%0d_addr got %h exp %h", n, dm_addr, exp_addr); else passes++;
               checks++; if (dm_byteen !== exp_be) $display("FAIL rnd%0d_byteen got %b exp %b", n, dm_byteen, exp_be); else passes++;
               checks++; if (dm_wdata !== exp_wd) $display("FAIL rnd%0d_wdata got %h exp %h", n, dm_wdata, exp_wd); else passes++;
               checks++; if (M_busy !== (w != nw)) $display("FAIL rnd%0d_busy got %h exp %h", n, M_busy, (w != nw)); else passes++;
               if (w == nw) begin
                  checks++; if (M_A3_W !== a3) $display("FAIL rnd%0d_a3 got %h exp %h", n, M_A3_W, a3); else passes++;
                  if (!st) begin
                     checks++; if (M_WD_W !== exp_ld) $display("FAIL rnd%0d_ld got %h exp %h", n, M_WD_W, exp_ld); else passes++;
                  end
               end else begin
                  checks++; if (M_A3_W !== 5'd0) $display("FAIL rnd%0d_bubble got %h exp 0", n, M_A3_W); else passes++;
               end
               @(negedge clk);
            end
            dm_ack = 1'b0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_sw_no_wait();
      test_lb_wait();
      test_sh_forward_hold();
      test_back_to_back();
      test_reset_mid_access();
      test_misaligned();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
